soc_sysid_ext: RTL

Parametrised Avalon-MM system-identification slave, successor to the fixed two-word sysid block. It exposes a configurable read-only identity and version space, a free-running 64-bit uptime counter with a coherent snapshot read, and a bank of software scratch registers. It sits on the SoC interconnect as a control slave beside the processor's other peripherals.

---
 rtl/soc_sysid_pkg.sv | 37 +++
 rtl/soc_sysid_uptime.sv | 53 +++++
 rtl/soc_sysid_ext.sv | 123 ++++++++++++
 3 files changed

// File: rtl/soc_sysid_pkg.sv
// Shared constants for the soc_sysid_ext system-identification slave.
// Word offsets of the register map, CTRL/CAPS bit positions and a
// byte-lane merge helper used by every writable register.
package soc_sysid_pkg;

    // Word offsets of the register map
    localparam int unsigned WORD_ID           = 0;
    localparam int unsigned WORD_TS           = 1;
    localparam int unsigned WORD_INFO         = 2;
    localparam int unsigned WORD_CAPS         = 3;
    localparam int unsigned WORD_UP_LO        = 4;
    localparam int unsigned WORD_UP_HI        = 5;
    localparam int unsigned WORD_CTRL         = 6;
    localparam int unsigned WORD_SCRATCH_BASE = 8;

    // CTRL bit positions (only byte lane 0 is decoded)
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    // CAPS bit positions
    localparam int unsigned CAPS_UPTIME_BIT = 0;

    // Replace only the byte lanes whose enable is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_sysid_uptime.sv
// Free-running 64-bit uptime counter with enable, clear pulse and a
// high-word shadow. The shadow is captured when latch_i is high so a
// LO read followed later by a HI read gives a consistent 64-bit value.
module soc_sysid_uptime (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_wr_i,   // CTRL written with lane 0 enabled
    input  logic        en_wdata_i,  // EN value carried by that write
    input  logic        clr_i,       // CLR bit set in that write
    input  logic        latch_i,     // UPTIME_LO being read this cycle
    output logic [31:0] count_lo_o,
    output logic [31:0] shadow_o,
    output logic        en_o
);

    logic [63:0] count_q;
    logic [31:0] shadow_q;
    logic        en_q;

    // EN register; comes out of reset counting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= 1'b1;
        end else if (ctrl_wr_i) begin
            en_q <= en_wdata_i;
        end
    end

    // Counter: clear wins over increment; increment gated by current EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 64'd0;
        end else if (clr_i) begin
            count_q <= 64'd0;
        end else if (en_q) begin
            count_q <= count_q + 64'd1;
        end
    end

    // High-word shadow captured alongside a LO read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= 32'd0;
        end else if (latch_i) begin
            shadow_q <= count_q[63:32];
        end
    end

    assign count_lo_o = count_q[31:0];
    assign shadow_o   = shadow_q;
    assign en_o       = en_q;

endmodule

// File: rtl/soc_sysid_ext.sv
// soc_sysid_ext: Avalon-MM system-identification slave.
// Read-only identity words, optional uptime counter, scratch bank and a
// registered read-data port with fixed one-cycle latency.
// Build option: define SOC_SYSID_UPTIME_EN to include the uptime counter,
// its HI shadow and the CTRL register; otherwise those words read 0.
//
// Bus handshake: there is no waitrequest, every read/write strobe is
// accepted in the cycle it is high; an accepted read produces exactly one
// readdatavalid pulse in the next cycle, and readdata then holds until the
// next accepted read. A simultaneous read and write both execute and the
// read observes the value from before the write.
module soc_sysid_ext
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter logic [15:0] HW_VERSION  = 16'h0001,
    parameter int          ADDR_W      = 4,
    parameter int          NUM_SCRATCH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    // Keep at least one array entry so a zero-scratch build stays legal
    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

    logic [31:0] scratch_q [SCR_N];
    logic [31:0] rd_data_d;

    function automatic logic hit(input logic [ADDR_W-1:0] a, input int unsigned w);
        return a == ADDR_W'(w);
    endfunction

`ifdef SOC_SYSID_UPTIME_EN
    logic        ctrl_wr;
    logic [31:0] up_count_lo;
    logic [31:0] up_shadow;
    logic        up_en;

    assign ctrl_wr = write && hit(address, WORD_CTRL) && byteenable[0];

    soc_sysid_uptime u_uptime (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_wr_i  (ctrl_wr),
        .en_wdata_i (writedata[CTRL_EN_BIT]),
        .clr_i      (ctrl_wr && writedata[CTRL_CLR_BIT]),
        .latch_i    (read && hit(address, WORD_UP_LO)),
        .count_lo_o (up_count_lo),
        .shadow_o   (up_shadow),
        .en_o       (up_en)
    );
`endif

    // Scratch bank: byte-lane writes to the addressed entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SCR_N; i++) begin
                scratch_q[i] <= 32'd0;
            end
        end else if (write) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (hit(address, WORD_SCRATCH_BASE + i)) begin
                    scratch_q[i] <= merge_bytes(scratch_q[i], writedata, byteenable);
                end
            end
        end
    end

    // Read mux over the word map; unmapped words read 0
    always_comb begin
        rd_data_d = 32'd0;
        if (hit(address, WORD_ID)) begin
            rd_data_d = SYSTEM_ID;
        end else if (hit(address, WORD_TS)) begin
            rd_data_d = TIMESTAMP;
        end else if (hit(address, WORD_INFO)) begin
            rd_data_d = {8'(NUM_SCRATCH), 8'(ADDR_W), HW_VERSION};
        end else if (hit(address, WORD_CAPS)) begin
`ifdef SOC_SYSID_UPTIME_EN
            rd_data_d[CAPS_UPTIME_BIT] = 1'b1;
`endif
        end
`ifdef SOC_SYSID_UPTIME_EN
        else if (hit(address, WORD_UP_LO)) begin
            rd_data_d = up_count_lo;
        end else if (hit(address, WORD_UP_HI)) begin
            rd_data_d = up_shadow;
        end else if (hit(address, WORD_CTRL)) begin
            rd_data_d[CTRL_EN_BIT] = up_en;
        end
`endif
        else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (hit(address, WORD_SCRATCH_BASE + i)) begin
                    rd_data_d = scratch_q[i];
                end
            end
        end
    end

    // Registered read port: data updates only on accepted reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_data_d;
            end
        end
    end

endmodule
